fu_mem_pipe: RTL and testbench

Pipelined, parametrised successor to the single-shot load FU. It accepts one load per cycle from the memory reservation station, keeps up to DEPTH loads outstanding against a fixed-latency synchronous data memory, and formats LB/LH/LW/LBU/LHU results. It returns results to the CDB in issue order through a valid/ready handshake. Entries younger than a mispredicted branch are flushed using ROB-window age comparison with wrap-around.

---
 rtl/fu_mem_pipe.sv | 166 ++++++++++++++++
 tb/tb_fu_mem_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_mem_pipe.sv
// Pipelined load functional unit: in-order circular queue of outstanding loads against a
// fixed-latency data memory, LB/LH/LW/LBU/LHU formatting, and ROB-age based flush.
module fu_mem_pipe #(
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 2,
   parameter int ROB_W   = 5,
   parameter int PREG_W  = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issued,
   output logic              issue_ready,
   input  logic [2:0]        func3,
   input  logic [31:0]       imm,
   input  logic [31:0]       ps1_data,
   input  logic [ROB_W-1:0]  rob_index,
   input  logic [PREG_W-1:0] pd,
   input  logic [ROB_W-1:0]  curr_rob_tag,
   input  logic              mispredict,
   input  logic [ROB_W-1:0]  mispredict_tag,
   output logic              mem_req,
   output logic [31:0]       mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [ROB_W-1:0]  out_rob_index,
   output logic [PREG_W-1:0] out_pd,
   output logic              busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef logic [PTR_W-1:0]   ptr_t;
   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [MEM_LAT-1:0] sr_t;

   // Slot control state (reset)
   logic [DEPTH-1:0] slot_valid;
   logic [DEPTH-1:0] slot_killed;
   logic [DEPTH-1:0] slot_dv;
   ptr_t             head, tail, resp;
   cnt_t             count;
   sr_t              req_sr;

   // Slot payload (not reset)
   logic [ROB_W-1:0]  rob_q  [DEPTH];
   logic [PREG_W-1:0] pd_q   [DEPTH];
   logic [2:0]        f3_q   [DEPTH];
   logic [1:0]        ea_q   [DEPTH];
   logic [31:0]       data_q [DEPTH];

   logic [31:0]      ea;
   logic             accept;
   logic             resp_hit;
   logic             head_ready;
   logic             drop;
   logic             dequeue;
   logic [DEPTH-1:0] kill_vec;

   // Wrap-around ROB window test: tag lies strictly after the branch and before the tail.
   function automatic logic is_younger(input logic [ROB_W-1:0] tag,
                                       input logic [ROB_W-1:0] br,
                                       input logic [ROB_W-1:0] rob_tail);
      logic [ROB_W-1:0] age;
      logic [ROB_W-1:0] range;
      age   = tag - br;
      range = rob_tail - br;
      return (age != '0) && (age < range);
   endfunction

   function automatic logic [31:0] load_format(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  ea_lo);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v = 8'(word >> {ea_lo, 3'b000});
      half_v = 16'(word >> {ea_lo[1], 4'b0000});
      case (f3)
         3'b000:  return {{24{byte_v[7]}}, byte_v};
         3'b001:  return {{16{half_v[15]}}, half_v};
         3'b010:  return word;
         3'b100:  return {24'h0, byte_v};
         3'b101:  return {16'h0, half_v};
         default: return '0;
      endcase
   endfunction

   always_comb begin
      ea          = ps1_data + imm;
      issue_ready = reset && (count < cnt_t'(DEPTH));
      accept      = issued && issue_ready &&
                    !(mispredict && is_younger(rob_index, mispredict_tag, curr_rob_tag));
      mem_req     = accept;
      mem_addr    = {ea[31:2], 2'b00};
      resp_hit    = req_sr[MEM_LAT-1];
      busy        = (count != '0);
   end

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      kill_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         kill_vec[i] = mispredict && slot_valid[i] &&
                       is_younger(rob_q[i], mispredict_tag, curr_rob_tag);
   end

   always_comb begin
      head_ready    = slot_valid[head] && slot_dv[head];
      out_valid     = head_ready && !slot_killed[head] &&
                      !(mispredict && is_younger(rob_q[head], mispredict_tag, curr_rob_tag));
      drop          = head_ready && slot_killed[head];
      dequeue       = drop || (out_valid && out_ready);
      out_data      = out_valid ? data_q[head] : '0;
      out_rob_index = out_valid ? rob_q[head]  : '0;
      out_pd        = out_valid ? pd_q[head]   : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so later statements see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_valid  <= '0;
         slot_killed <= '0;
         slot_dv     <= '0;
         head        <= '0;
         tail        <= '0;
         resp        <= '0;
         count       <= '0;
         req_sr      <= '0;
      end else begin
         slot_killed <= slot_killed | kill_vec;
         if (accept) begin
            slot_valid[tail]  <= 1'b1;
            slot_killed[tail] <= 1'b0;
            slot_dv[tail]     <= 1'b0;
            tail              <= tail + ptr_t'(1);
         end
         if (resp_hit) begin
            slot_dv[resp] <= 1'b1;
            resp          <= resp + ptr_t'(1);
         end
         if (dequeue) begin
            slot_valid[head]  <= 1'b0;
            slot_killed[head] <= 1'b0;
            slot_dv[head]     <= 1'b0;
            head              <= head + ptr_t'(1);
         end
         count  <= count + cnt_t'(accept) - cnt_t'(dequeue);
         req_sr <= sr_t'({req_sr, accept});
      end
   end

   // NOTE: payload storage is not reset; it is only ever observed behind a reset valid bit.
   always_ff @(posedge clk) begin
      if (accept) begin
         rob_q[tail] <= rob_index;
         pd_q[tail]  <= pd;
         f3_q[tail]  <= func3;
         ea_q[tail]  <= ea[1:0];
      end
      if (resp_hit)
         data_q[resp] <= load_format(mem_rdata, f3_q[resp], ea_q[resp]);
   end

endmodule

// File: tb/tb_fu_mem_pipe.sv
// Scoreboard bench for fu_mem_pipe: a fixed-latency memory model answers requests, expected
// results are queued at issue and compared in order as the unit hands them to the CDB.
module tb_fu_mem_pipe;

   localparam int DEPTH   = 4;
   localparam int MEM_LAT = 2;
   localparam int ROB_W   = 5;
   localparam int PREG_W  = 7;

   typedef logic [ROB_W-1:0]  rob_t;
   typedef logic [PREG_W-1:0] preg_t;

   typedef struct packed {
      logic [31:0] data;
      rob_t        rob;
      preg_t       pd;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        issued;
   logic        issue_ready;
   logic [2:0]  func3;
   logic [31:0] imm;
   logic [31:0] ps1_data;
   rob_t        rob_index;
   preg_t       pd;
   rob_t        curr_rob_tag;
   logic        mispredict;
   rob_t        mispredict_tag;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   rob_t        out_rob_index;
   preg_t       out_pd;
   logic        busy;

   fu_mem_pipe #(
      .DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .ROB_W(ROB_W), .PREG_W(PREG_W)
   ) dut (
      .clk(clk), .reset(reset), .issued(issued), .issue_ready(issue_ready),
      .func3(func3), .imm(imm), .ps1_data(ps1_data), .rob_index(rob_index), .pd(pd),
      .curr_rob_tag(curr_rob_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rob_index(out_rob_index), .out_pd(out_pd), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t sb_head;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr[31:2])
         30'd0:   return 32'h4433_2211;
         30'd1:   return 32'h80FF_7F01;
         default: return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
      endcase
   endfunction

   // Memory model: a request seen in cycle t is answered throughout cycle t+MEM_LAT.
   logic [31:0] pipe_a [MEM_LAT];
   logic        pipe_v [MEM_LAT];
   initial begin
      mem_rdata = 32'hDEAD_BEEF;
      foreach (pipe_v[i]) begin
         pipe_v[i] = 1'b0;
         pipe_a[i] = '0;
      end
   end
   always @(negedge clk) begin
      mem_rdata = pipe_v[MEM_LAT-1] ? mem_word(pipe_a[MEM_LAT-1]) : 32'hDEAD_BEEF;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
         pipe_v[i] = pipe_v[i-1];
         pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0] = mem_req;
      pipe_a[0] = mem_addr;
   end

   // Result monitor: every accepted CDB transfer must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            sb_head = sb.pop_front();
            check("out_data", out_data, sb_head.data);
            check("out_rob", 32'(out_rob_index), 32'(sb_head.rob));
            check("out_pd", 32'(out_pd), 32'(sb_head.pd));
         end
      end
   end

   // Called at posedge+1; drives one issue cycle and returns at the next posedge+1.
   task automatic issue_ld(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] off,
                           input rob_t rob, input preg_t dst, input logic exp_rdy,
                           input logic exp_acc, input logic keep, input logic [31:0] exp_data);
      logic [31:0] ea;
      ea        = base + off;
      issued    = 1'b1;
      func3     = f3;
      ps1_data  = base;
      imm       = off;
      rob_index = rob;
      pd        = dst;
      @(negedge clk);
      check("issue_ready", 32'(issue_ready), 32'(exp_rdy));
      check("mem_req", 32'(mem_req), 32'(exp_acc));
      if (exp_acc) check("mem_addr", mem_addr, {ea[31:2], 2'b00});
      if (exp_acc && keep) sb.push_back('{data: exp_data, rob: rob, pd: dst});
      @(posedge clk);
      #1;
      issued = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      check("drain_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"}, out_data, 32'd0);
      check({tag, "_out_rob"}, 32'(out_rob_index), 32'd0);
      check({tag, "_out_pd"}, 32'(out_pd), 32'd0);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_issue_ready"}, 32'(issue_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b0;
      issued         = 1'b1;
      func3          = 3'b010;
      ps1_data       = 32'h10;
      imm            = '0;
      rob_index      = 5'd1;
      pd             = 7'd1;
      curr_rob_tag   = '0;
      mispredict     = 1'b0;
      mispredict_tag = '0;
      out_ready      = 1'b1;
      #3;
      check_reset_outputs("por");
      issued = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Latency: accept in t, out_valid in t+3, busy clears after the dequeue
      issue_ld(3'b010, 32'd0, 32'd0, 5'd1, 7'd9, 1'b1, 1'b1, 1'b1, 32'h4433_2211);
      @(negedge clk);
      check("lat_t1_valid", 32'(out_valid), 32'd0);
      check("lat_t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("lat_t2_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_t3_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("lat_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Formatting, issued back to back at full throughput
      issue_ld(3'b000, 32'd4, 32'd3, 5'd2, 7'd10, 1'b1, 1'b1, 1'b1, 32'hFFFF_FF80);
      issue_ld(3'b100, 32'd4, 32'd3, 5'd3, 7'd11, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
      issue_ld(3'b001, 32'd4, 32'd2, 5'd4, 7'd12, 1'b1, 1'b1, 1'b1, 32'hFFFF_80FF);
      issue_ld(3'b101, 32'd0, 32'd6, 5'd5, 7'd13, 1'b1, 1'b1, 1'b1, 32'h0000_80FF);
      issue_ld(3'b100, 32'd0, 32'd1, 5'd6, 7'd14, 1'b1, 1'b1, 1'b1, 32'h0000_0022);
      issue_ld(3'b010, 32'd5, 32'd0, 5'd7, 7'd15, 1'b1, 1'b1, 1'b1, 32'h80FF_7F01);
      issue_ld(3'b011, 32'd0, 32'd0, 5'd8, 7'd16, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
      issue_ld(3'b001, 32'hFFFF_FFFC, 32'h0000_000A, 5'd9, 7'd17, 1'b1, 1'b1, 1'b1, 32'hFFFF_80FF);
      wait_idle(20);

      // Backpressure: fill the queue, refuse a fifth, hold data, then drain one per cycle
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         issue_ld(3'b010, 32'(i * 4), 32'd0, rob_t'(i + 1), preg_t'(20 + i),
                  1'b1, 1'b1, 1'b1, mem_word(32'(i * 4)));
      issue_ld(3'b010, 32'd16, 32'd0, 5'd5, 7'd25, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", out_data, 32'h4433_2211);
         check("stall_rob", 32'(out_rob_index), 32'd1);
         check("stall_issue_ready", 32'(issue_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("drain_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      check("drain_done_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      wait_idle(10);

      // A younger head is masked in the same cycle mispredict rises, then dropped
      curr_rob_tag = 5'd8;
      out_ready    = 1'b0;
      issue_ld(3'b010, 32'd0, 32'd0, 5'd5, 7'd30, 1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mask_pre_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      mispredict     = 1'b1;
      mispredict_tag = 5'd3;
      @(negedge clk);
      check("mask_comb_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      mispredict = 1'b0;
      @(negedge clk);
      check("mask_killed_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      wait_idle(10);

      // Flush: rob 2 survives, rob 5 is killed in flight, rob 6 is refused
      issue_ld(3'b010, 32'd0, 32'd0, 5'd2, 7'd31, 1'b1, 1'b1, 1'b1, 32'h4433_2211);
      issue_ld(3'b010, 32'd4, 32'd0, 5'd5, 7'd32, 1'b1, 1'b1, 1'b0, 32'd0);
      mispredict     = 1'b1;
      mispredict_tag = 5'd3;
      issue_ld(3'b010, 32'd8, 32'd0, 5'd6, 7'd33, 1'b1, 1'b0, 1'b0, 32'd0);
      mispredict = 1'b0;
      wait_idle(10);

      // Wrap-around flush window 30 -> 2: rob 31 and rob 1 killed, rob 29 completes
      curr_rob_tag = 5'd2;
      issue_ld(3'b010, 32'd0, 32'd0, 5'd29, 7'd40, 1'b1, 1'b1, 1'b1, 32'h4433_2211);
      issue_ld(3'b010, 32'd4, 32'd0, 5'd31, 7'd41, 1'b1, 1'b1, 1'b0, 32'd0);
      issue_ld(3'b010, 32'd8, 32'd0, 5'd1, 7'd42, 1'b1, 1'b1, 1'b0, 32'd0);
      mispredict     = 1'b1;
      mispredict_tag = 5'd30;
      @(posedge clk);
      #1;
      mispredict = 1'b0;
      wait_idle(10);

      // Reset with loads in flight: outputs clear at once, stale responses never emerge
      issue_ld(3'b010, 32'd0, 32'd0, 5'd1, 7'd50, 1'b1, 1'b1, 1'b0, 32'd0);
      issue_ld(3'b010, 32'd4, 32'd0, 5'd2, 7'd51, 1'b1, 1'b1, 1'b0, 32'd0);
      issue_ld(3'b010, 32'd8, 32'd0, 5'd3, 7'd52, 1'b1, 1'b1, 1'b0, 32'd0);
      #1;
      reset     = 1'b0;
      issued    = 1'b1;
      rob_index = 5'd4;
      #1;
      check_reset_outputs("mid");
      issued = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      issue_ld(3'b010, 32'd0, 32'd0, 5'd7, 7'd3, 1'b1, 1'b1, 1'b1, 32'h4433_2211);
      wait_idle(10);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
